// File: rtl/double_adder_issue_queue.sv
// Circular issue queue that feeds double_adder_pipe operands in FIFO order.
// Optional same-cycle bypass into an empty queue: define DOUBLE_ADDER_ISSUE_BYPASS_EN.
module double_adder_issue_queue #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned TAG   = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [63:0]             in_a,
   input  logic [63:0]             in_b,
   input  logic [63:0]             in_mult_operand,
   input  logic [TAG-1:0]          in_tag,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    adder_stall,
   input  logic                    global_stall,
   output logic [63:0]             input_a,
   output logic [63:0]             input_b,
   output logic [63:0]             mult_operand_in,
   output logic [TAG-1:0]          tag_in,
   output logic                    input_valid,
   output logic [$clog2(DEPTH):0]  occupancy,
   output logic                    overflow
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam logic [PtrW:0] Full = (PtrW + 1)'(DEPTH);

   typedef struct packed {
      logic [TAG-1:0] tag;
      logic [63:0]    m;
      logic [63:0]    b;
      logic [63:0]    a;
   } entry_t;

   entry_t          mem_q [DEPTH];
   entry_t          head;
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PtrW:0]   occ_q, occ_d;
   logic            overflow_q, overflow_d;
   logic            issue_ok, empty, full, push, pop, bypass;

   always_comb begin
      empty    = (occ_q == '0);
      full     = (occ_q == Full);
      issue_ok = !adder_stall && !global_stall;
      in_ready = !full;
`ifdef DOUBLE_ADDER_ISSUE_BYPASS_EN
      // An empty queue hands the offered entry straight to the adder.
      bypass   = empty && issue_ok && in_valid;
`else
      bypass   = 1'b0;
`endif
      push        = in_valid && in_ready && !bypass;
      pop         = !empty && issue_ok;
      input_valid = pop || bypass;
      occupancy   = occ_q;
      overflow    = overflow_q;

      head = mem_q[rd_ptr_q];
      if (bypass) begin
         input_a         = in_a;
         input_b         = in_b;
         mult_operand_in = in_mult_operand;
         tag_in          = in_tag;
      end else begin
         input_a         = head.a;
         input_b         = head.b;
         mult_operand_in = head.m;
         tag_in          = head.tag;
      end
   end

   always_comb begin
      wr_ptr_d   = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
      overflow_d = overflow_q || (in_valid && !in_ready);
      occ_d      = occ_q;
      unique case ({push, pop})
         2'b10:   occ_d = occ_q + (PtrW + 1)'(1);
         2'b01:   occ_d = occ_q - (PtrW + 1)'(1);
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         occ_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         occ_q      <= occ_d;
         overflow_q <= overflow_d;
      end
   end

   // Payload storage is deliberately unreset; occupancy alone marks validity.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= '{tag: in_tag, m: in_mult_operand, b: in_b, a: in_a};
      end
   end

endmodule

// File: tb/tb_double_adder_issue_queue.sv
// Directed bench for double_adder_issue_queue (DEPTH=8, TAG=8); also exercises the
// DOUBLE_ADDER_ISSUE_BYPASS_EN build when that macro is defined.
module tb_double_adder_issue_queue;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] in_a, in_b, in_mult_operand;
   logic [7:0]  in_tag;
   logic        in_valid, in_ready, adder_stall, global_stall;
   logic [63:0] input_a, input_b, mult_operand_in;
   logic [7:0]  tag_in;
   logic        input_valid;
   logic [3:0]  occupancy;
   logic        overflow;

   int total = 0;
   int bad   = 0;

   double_adder_issue_queue #(.DEPTH(8), .TAG(8)) dut (
      .clk(clk), .reset(reset), .in_a(in_a), .in_b(in_b),
      .in_mult_operand(in_mult_operand), .in_tag(in_tag), .in_valid(in_valid),
      .in_ready(in_ready), .adder_stall(adder_stall), .global_stall(global_stall),
      .input_a(input_a), .input_b(input_b), .mult_operand_in(mult_operand_in),
      .tag_in(tag_in), .input_valid(input_valid), .occupancy(occupancy),
      .overflow(overflow)
   );

   always #5 clk = !clk;

   typedef struct {
      logic       iv, as, gs;
      logic [7:0] tag;
      logic       rdy, vld;
      logic [7:0] etag;
      logic [3:0] occ;
      logic       ovf;
   } vec_t;

   vec_t vecs [17];

   function automatic logic [63:0] mk_a(input logic [7:0] t);
      return 64'h3FF0_0000_0000_0000 | {56'h0, t};
   endfunction

   function automatic logic [63:0] mk_b(input logic [7:0] t);
      return 64'h4000_0000_0000_0000 | {48'h0, t, 8'h0};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic iv, input logic as, input logic gs, input logic [7:0] t);
      in_valid        = iv;
      adder_stall     = as;
      global_stall    = gs;
      in_tag          = t;
      in_a            = mk_a(t);
      in_b            = mk_b(t);
      in_mult_operand = {56'hABCD_0000_0000_00, t};
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Stall-only pushes so every row holds with or without bypass.
      vecs[0] = '{0, 0, 0, 8'd0, 1, 0, 8'd0, 4'd0, 0};
      for (int k = 1; k <= 8; k++)
         vecs[k] = '{1, 1, 0, 8'(k), 1, 0, 8'd0, 4'(k - 1), 0};
      vecs[9]  = '{1, 1, 0, 8'd9,  0, 0, 8'd0, 4'd8, 0};
      vecs[10] = '{1, 0, 0, 8'd10, 0, 1, 8'd1, 4'd8, 1};
      vecs[11] = '{1, 0, 0, 8'd11, 1, 1, 8'd2, 4'd7, 1};
      vecs[12] = '{0, 0, 1, 8'd0,  1, 0, 8'd0, 4'd7, 1};
      vecs[13] = '{0, 0, 1, 8'd0,  1, 0, 8'd0, 4'd7, 1};
      vecs[14] = '{0, 0, 0, 8'd0,  1, 1, 8'd3, 4'd7, 1};
      vecs[15] = '{1, 0, 1, 8'd12, 1, 0, 8'd0, 4'd6, 1};
      vecs[16] = '{0, 0, 0, 8'd0,  1, 1, 8'd4, 4'd7, 1};

      reset = 1'b1;
      drive(0, 0, 0, 8'd0);
      #1;
      chk("reset_occ", 64'(occupancy), 64'd0);
      chk("reset_ready", 64'(in_ready), 64'd1);
      chk("reset_valid", 64'(input_valid), 64'd0);
      chk("reset_ovf", 64'(overflow), 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;

      for (int i = 0; i < 17; i++) begin
         drive(vecs[i].iv, vecs[i].as, vecs[i].gs, vecs[i].tag);
         #1;
         chk($sformatf("v%0d_ready", i), 64'(in_ready), 64'(vecs[i].rdy));
         chk($sformatf("v%0d_valid", i), 64'(input_valid), 64'(vecs[i].vld));
         chk($sformatf("v%0d_occ", i), 64'(occupancy), 64'(vecs[i].occ));
         chk($sformatf("v%0d_ovf", i), 64'(overflow), 64'(vecs[i].ovf));
         if (vecs[i].vld) begin
            chk($sformatf("v%0d_tag", i), 64'(tag_in), 64'(vecs[i].etag));
            chk($sformatf("v%0d_a", i), input_a, mk_a(vecs[i].etag));
         end
         next_cycle();
      end

      // Asynchronous reset mid-cycle with entries still queued.
      drive(0, 1, 0, 8'd0);
      #3 reset = 1'b1;
      #1;
      chk("async_occ", 64'(occupancy), 64'd0);
      chk("async_ovf", 64'(overflow), 64'd0);
      chk("async_ready", 64'(in_ready), 64'd1);
      chk("async_valid", 64'(input_valid), 64'd0);
      next_cycle();
      reset = 1'b0;
      drive(0, 0, 0, 8'd0);
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("post_reset_valid", 64'(input_valid), 64'd0);
         chk("post_reset_occ", 64'(occupancy), 64'd0);
         next_cycle();
      end

      // Single push with the adder free.
      drive(1, 0, 0, 8'd5);
      in_a = 64'h3FF0_0000_0000_0000;
      in_b = 64'h4000_0000_0000_0000;
      #1;
`ifdef DOUBLE_ADDER_ISSUE_BYPASS_EN
      chk("byp_valid", 64'(input_valid), 64'd1);
      chk("byp_tag", 64'(tag_in), 64'd5);
      chk("byp_a", input_a, 64'h3FF0_0000_0000_0000);
      chk("byp_b", input_b, 64'h4000_0000_0000_0000);
`else
      chk("push_same_cycle_valid", 64'(input_valid), 64'd0);
`endif
      next_cycle();
      drive(0, 0, 0, 8'd0);
      #1;
`ifdef DOUBLE_ADDER_ISSUE_BYPASS_EN
      chk("byp_occ", 64'(occupancy), 64'd0);
      chk("byp_no_reissue", 64'(input_valid), 64'd0);
`else
      chk("issue_valid", 64'(input_valid), 64'd1);
      chk("issue_tag", 64'(tag_in), 64'd5);
      chk("issue_a", input_a, 64'h3FF0_0000_0000_0000);
      chk("issue_b", input_b, 64'h4000_0000_0000_0000);
      chk("issue_occ", 64'(occupancy), 64'd1);
`endif
      next_cycle();
      #1;
      chk("drained_occ", 64'(occupancy), 64'd0);
      chk("drained_valid", 64'(input_valid), 64'd0);
      next_cycle();

      // 20 tagged pushes under a random adder stall, crossing the pointer wrap.
      begin
         int nxt = 0;
         int exp_tag = 0;
         int cyc = 0;
         while (exp_tag < 20 && cyc < 400) begin
            drive(nxt < 20, 1'($urandom_range(0, 1)), 0, 8'(nxt));
            #1;
            if (input_valid) begin
               chk("order_tag", 64'(tag_in), 64'(exp_tag));
               exp_tag++;
            end
            if (in_valid && in_ready) nxt++;
            next_cycle();
            cyc++;
         end
         chk("order_count", 64'(exp_tag), 64'd20);
         chk("order_pushed", 64'(nxt), 64'd20);
      end
      drive(0, 0, 0, 8'd0);
      #1;
      chk("order_empty_valid", 64'(input_valid), 64'd0);
      chk("order_empty_occ", 64'(occupancy), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
